// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line data cache controller with a read-miss refill
// path, a write-through store path, and saturating read hit/miss counters.
module cache_ctrl #(
   parameter int ADDRESS_WIDTH = 3,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_rd,
   input  logic                  cpu_wr,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  stall,
   input  logic                  flush,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
);

   localparam int LINES = 2 ** ADDRESS_WIDTH;
   localparam int TAG_W = 32 - ADDRESS_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

   state_t                  state;
   logic [LINES-1:0]        valid;
   logic [TAG_W-1:0]        tag_mem  [LINES];
   logic [DATA_WIDTH-1:0]   data_mem [LINES];

   logic [ADDRESS_WIDTH-1:0] idx;
   logic [TAG_W-1:0]         tag;
   logic [ADDRESS_WIDTH-1:0] m_idx;
   logic [TAG_W-1:0]         m_tag;
   logic                     hit;
   logic                     wr_hit;
   logic                     unused_addr_bits;

   assign idx    = cpu_addr[ADDRESS_WIDTH+1:2];
   assign tag    = cpu_addr[31:ADDRESS_WIDTH+2];
   // The registered memory address doubles as the latched address of the pending access
   assign m_idx  = mem_addr[ADDRESS_WIDTH+1:2];
   assign m_tag  = mem_addr[31:ADDRESS_WIDTH+2];
   assign hit    = valid[idx] && (tag_mem[idx] == tag);
   assign wr_hit = valid[m_idx] && (tag_mem[m_idx] == m_tag);
   assign unused_addr_bits = ^cpu_addr[1:0];

   always_comb begin
      stall     = 1'b0;
      cpu_rdata = '0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (cpu_wr) begin
                  stall = 1'b1;
               end else if (cpu_rd) begin
                  if (hit) cpu_rdata = data_mem[idx];
                  else     stall = 1'b1;
               end
            end
            RD_MISS: begin
               if (mem_ack) cpu_rdata = mem_rdata;
               else         stall = 1'b1;
            end
            WR_THRU: stall = !mem_ack;
            default: stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         valid     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) valid <= '0;
               if (cpu_wr) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {cpu_addr[31:2], 2'b00};
                  mem_wdata <= cpu_wdata;
                  state     <= WR_THRU;
               end else if (cpu_rd) begin
                  if (hit) begin
                     if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                  end else begin
                     if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= {cpu_addr[31:2], 2'b00};
                     state    <= RD_MISS;
                  end
               end
            end
            RD_MISS: begin
               if (mem_ack) begin
                  valid[m_idx] <= 1'b1;
                  mem_req      <= 1'b0;
                  state        <= IDLE;
               end
            end
            WR_THRU: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data storage carry no reset; only the valid bits decide what is live
   always_ff @(posedge clk) begin
      if (state == RD_MISS && mem_ack) begin
         data_mem[m_idx] <= mem_rdata;
         tag_mem[m_idx]  <= m_tag;
      end else if (state == WR_THRU && mem_ack && wr_hit) begin
         data_mem[m_idx] <= mem_wdata;
      end
   end

endmodule
